// File: rtl/riscq_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : riscq_prog_loader
// Purpose  : Parses framed byte packets from a host link and issues 32-bit
//            word writes into the RISCQ instruction ROM / data RAM init
//            ports. Raises the init_done levels that release the core and
//            flags framing and checksum errors.
// Revision : 1.0 - initial release
// ============================================================================
module riscq_prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_inst_waddr,
  output logic [31:0]       o_inst_wdata,
  output logic              o_inst_we,
  output logic              o_inst_init_done,
  output logic [ADDR_W-1:0] o_data_waddr,
  output logic [31:0]       o_data_wdata,
  output logic              o_data_we,
  output logic              o_data_init_done,
  output logic              o_busy,
  output logic              o_err,
  output logic [7:0]        o_pkt_cnt
);

  localparam logic [7:0] C_TGT_INST = 8'h01;
  localparam logic [7:0] C_TGT_DATA = 8'h02;
  localparam logic [7:0] C_TGT_DONE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TGT    = 3'd1,
    S_CNT_L  = 3'd2,
    S_CNT_H  = 3'd3,
    S_ADDR_L = 3'd4,
    S_ADDR_H = 3'd5,
    S_DATA   = 3'd6,
    S_CSUM   = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_ready;
  logic [7:0]        r_csum;
  logic              r_tgt_data;   // 0: instruction memory, 1: data memory
  logic [7:0]        r_cnt_l;
  logic [15:0]       r_words_left;
  logic [7:0]        r_addr_l;
  logic [ADDR_W-1:0] r_wptr;       // address of the word being assembled
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;       // low three bytes of the word in flight
  logic [ADDR_W-1:0] r_inst_waddr;
  logic [31:0]       r_inst_wdata;
  logic              r_inst_we;
  logic [ADDR_W-1:0] r_data_waddr;
  logic [31:0]       r_data_wdata;
  logic              r_data_we;
  logic              r_inst_done;
  logic              r_data_done;
  logic              r_err;
  logic [7:0]        r_pkt_cnt;

  // Once both memories are loaded the link keeps draining but nothing reacts.
  logic w_accept;
  assign w_accept = i_rx_valid && r_rx_ready && !(r_inst_done && r_data_done);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode for the packet framing
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        S_IDLE:   if (i_rx_data == SYNC_BYTE) w_state_nxt = S_TGT;
        S_TGT:    w_state_nxt = (i_rx_data == C_TGT_INST || i_rx_data == C_TGT_DATA)
                                ? S_CNT_L : S_IDLE;
        S_CNT_L:  w_state_nxt = S_CNT_H;
        S_CNT_H:  w_state_nxt = S_ADDR_L;
        S_ADDR_L: w_state_nxt = S_ADDR_H;
        S_ADDR_H: w_state_nxt = (r_words_left == 16'd0) ? S_CSUM : S_DATA;
        S_DATA:   if (r_byte_idx == 2'd3 && r_words_left == 16'd1) w_state_nxt = S_CSUM;
        S_CSUM:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: checksum, header capture, word assembly, write strobes, status
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_ready   <= 1'b0;
      r_csum       <= 8'h00;
      r_tgt_data   <= 1'b0;
      r_cnt_l      <= 8'h00;
      r_words_left <= 16'h0000;
      r_addr_l     <= 8'h00;
      r_wptr       <= '0;
      r_byte_idx   <= 2'd0;
      r_word       <= 24'h000000;
      r_inst_waddr <= '0;
      r_inst_wdata <= 32'h0;
      r_inst_we    <= 1'b0;
      r_data_waddr <= '0;
      r_data_wdata <= 32'h0;
      r_data_we    <= 1'b0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_err        <= 1'b0;
      r_pkt_cnt    <= 8'h00;
    end else begin
      r_rx_ready <= 1'b1;
      r_inst_we  <= 1'b0;
      r_data_we  <= 1'b0;
      if (w_accept) begin
        // Every header/data byte between SYNC and CSUM feeds the checksum.
        if (r_state != S_IDLE && r_state != S_CSUM)
          r_csum <= r_csum ^ i_rx_data;
        case (r_state)
          S_IDLE: begin
            if (i_rx_data == SYNC_BYTE) r_csum <= 8'h00;
          end
          S_TGT: begin
            if (i_rx_data == C_TGT_INST) begin
              r_tgt_data <= 1'b0;
            end else if (i_rx_data == C_TGT_DATA) begin
              r_tgt_data <= 1'b1;
            end else if (i_rx_data == C_TGT_DONE) begin
              r_inst_done <= 1'b1;
              r_data_done <= 1'b1;
              r_pkt_cnt   <= r_pkt_cnt + 8'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
          S_CNT_L:  r_cnt_l      <= i_rx_data;
          S_CNT_H:  r_words_left <= {i_rx_data, r_cnt_l};
          S_ADDR_L: r_addr_l     <= i_rx_data;
          S_ADDR_H: begin
            r_wptr     <= ADDR_W'({i_rx_data, r_addr_l});
            r_byte_idx <= 2'd0;
          end
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= i_rx_data;
              2'd1: r_word[15:8]  <= i_rx_data;
              2'd2: r_word[23:16] <= i_rx_data;
              default: begin
                // Word complete: strobe the selected memory next cycle.
                r_wptr       <= r_wptr + ADDR_W'(1);
                r_words_left <= r_words_left - 16'd1;
                if (r_tgt_data) begin
                  r_data_we    <= 1'b1;
                  r_data_waddr <= r_wptr;
                  r_data_wdata <= {i_rx_data, r_word};
                end else begin
                  r_inst_we    <= 1'b1;
                  r_inst_waddr <= r_wptr;
                  r_inst_wdata <= {i_rx_data, r_word};
                end
              end
            endcase
          end
          S_CSUM: begin
            if (i_rx_data == r_csum) r_pkt_cnt <= r_pkt_cnt + 8'd1;
            else                     r_err     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_ready       = r_rx_ready;
  assign o_inst_waddr     = r_inst_waddr;
  assign o_inst_wdata     = r_inst_wdata;
  assign o_inst_we        = r_inst_we;
  assign o_inst_init_done = r_inst_done;
  assign o_data_waddr     = r_data_waddr;
  assign o_data_wdata     = r_data_wdata;
  assign o_data_we        = r_data_we;
  assign o_data_init_done = r_data_done;
  assign o_busy           = (r_state != S_IDLE);
  assign o_err            = r_err;
  assign o_pkt_cnt        = r_pkt_cnt;

endmodule
`default_nettype wire
